// File: rtl/imm_rot_encoder.sv
// Encodes a 32-bit constant as a 12-bit operand-2 field: rotated 8-bit immediate
// (searched one rotate step per cycle) or a plain 12-bit memory offset.
module imm_rot_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_cmd,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        encodable,
    output logic [11:0] shift_operand
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state;
    logic [31:0] val_q;
    logic [3:0]  rot;
    logic [31:0] cand;

    // Rotate left by 2*r without losing bits.
    function automatic logic [31:0] rotl2(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] d;
        d = {v, v} << {r, 1'b0};
        return d[63:32];
    endfunction

    assign cand = rotl2(val_q, rot);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rot           <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            encodable     <= 1'b0;
            shift_operand <= 12'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        val_q <= value;
                        if (mem_cmd) begin
                            state         <= DONE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            encodable     <= (value[31:12] == 20'd0);
                            shift_operand <= (value[31:12] == 20'd0) ? value[11:0] : 12'd0;
                        end else begin
                            state         <= SEARCH;
                            busy          <= 1'b1;
                            rot           <= 4'd0;
                            encodable     <= 1'b0;
                            shift_operand <= 12'd0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SEARCH: begin
                    // Ascending rot order makes the first hit the canonical encoding.
                    if (cand[31:8] == 24'd0) begin
                        shift_operand <= {rot, cand[7:0]};
                        encodable     <= 1'b1;
                        state         <= DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else if (rot == 4'd15) begin
                        shift_operand <= 12'd0;
                        encodable     <= 1'b0;
                        state         <= DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else begin
                        rot <= rot + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Self-checking bench for imm_rot_encoder: directed vector table, handshake and
// reset corner cases, and a randomized sweep against a decode-based reference.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_cmd = 1'b0;
    logic [31:0] value = 32'd0;
    logic        busy, done, encodable;
    logic [11:0] shift_operand;

    int n_chk  = 0;
    int n_fail = 0;

    imm_rot_encoder dut (
        .clk(clk), .rst(rst), .start(start), .mem_cmd(mem_cmd), .value(value),
        .busy(busy), .done(done), .encodable(encodable), .shift_operand(shift_operand)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] v, input int sh);
        logic [63:0] d;
        d = {v, v} >> (sh % 32);
        return d[31:0];
    endfunction

    // Reference: try each rotate in ascending order; accept the first whose
    // 8-bit immediate decodes back to the value exactly.
    function automatic void model(input logic [31:0] v, input bit mem,
                                  output int lat, output bit enc, output logic [11:0] op);
        logic [31:0] imm;
        enc = 0; op = 12'd0; lat = 17;
        if (mem) begin
            lat = 1;
            if (v < 32'h1000) begin enc = 1; op = v[11:0]; end
            return;
        end
        for (int r = 0; r < 16; r++) begin
            imm = ror(v, 32 - 2 * r);
            if (imm < 32'd256 && ror(imm, 2 * r) == v) begin
                enc = 1; op = {r[3:0], imm[7:0]}; lat = r + 2;
                return;
            end
        end
    endfunction

    // Launch one request; return measured latency (-1 on timeout).
    task automatic launch_and_wait(input logic [31:0] v, input bit mem, output int lat);
        int cyc;
        @(negedge clk);
        value = v; mem_cmd = mem; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; lat = -1;
        while (lat < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy && done) chk("busy_and_done", 1, 0);
            if (done) lat = cyc;
        end
    endtask

    task automatic run(input string name, input logic [31:0] v, input bit mem,
                       input int exp_lat, input bit exp_enc, input logic [11:0] exp_op);
        int lat;
        launch_and_wait(v, mem, lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_enc"}, encodable, exp_enc);
        chk({name, "_op"}, shift_operand, exp_op);
    endtask

    typedef struct {
        logic [31:0] v;
        bit          mem;
        int          lat;
        bit          enc;
        logic [11:0] op;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, elat;
        bit eenc;
        logic [11:0] eop, hold_op;
        logic hold_enc;
        int seen_done;
        logic [31:0] v, imm;
        bit mem;

        vecs[0] = '{32'h0000_00FF, 0, 2,  1, 12'h0FF};
        vecs[1] = '{32'hFF00_0000, 0, 6,  1, 12'h4FF};
        vecs[2] = '{32'h0000_0102, 0, 17, 0, 12'h000};
        vecs[3] = '{32'hF000_000F, 0, 4,  1, 12'h2FF};
        vecs[4] = '{32'h0000_0ABC, 1, 1,  1, 12'hABC};
        vecs[5] = '{32'h0000_1000, 1, 1,  0, 12'h000};
        vecs[6] = '{32'h0000_0000, 0, 2,  1, 12'h000};
        vecs[7] = '{32'h0000_03FC, 0, 17, 1, 12'hFFF};
        // 0x3FC = 0xFF << 2 = ror(0xFF, 30), so rot=15 is the only match
        vecs[7].lat = 17;

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enc", encodable, 0);
        chk("rst_op", shift_operand, 0);
        repeat (3) @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_op", shift_operand, 0);

        // Directed table
        foreach (vecs[i]) begin
            run($sformatf("vec%0d", i), vecs[i].v, vecs[i].mem, vecs[i].lat, vecs[i].enc, vecs[i].op);
            hold_enc = encodable; hold_op = shift_operand;
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_hold", i), {hold_enc, hold_op}, {encodable, shift_operand});
            chk($sformatf("vec%0d_hold_ref", i), {encodable, shift_operand}, {vecs[i].enc, vecs[i].op});
        end

        // Start during SEARCH is ignored
        @(negedge clk);
        value = 32'hFF00_0000; mem_cmd = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        value = 32'h0000_00AB; mem_cmd = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1;
        for (int c = 2; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (done) lat = c;
        end
        chk("ignore_lat", lat, 6);
        chk("ignore_op", shift_operand, 12'h4FF);
        chk("ignore_enc", encodable, 1);

        // Start during DONE cycle is accepted back-to-back
        @(posedge clk); #1;
        value = 32'h0000_0ABC; mem_cmd = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_mem_done", done, 1);
        chk("b2b_mem_op", shift_operand, 12'hABC);
        value = 32'h0000_00FF; mem_cmd = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_dp_busy", busy, 1);
        chk("b2b_dp_cleared", shift_operand, 0);
        @(negedge clk);
        chk("b2b_dp_done", done, 1);
        chk("b2b_dp_op", shift_operand, 12'h0FF);

        // Reset mid-SEARCH aborts with no done pulse
        @(negedge clk);
        value = 32'h0000_0102; mem_cmd = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_enc", encodable, 0);
        chk("abort_op", shift_operand, 0);

        // Randomized sweep
        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 3)
                0: begin
                    imm = 32'($urandom % 256);
                    v = ror(imm, 2 * int'($urandom % 16));
                    mem = 0;
                end
                1: begin v = $urandom; mem = 0; end
                default: begin
                    v = ($urandom % 2) ? 32'($urandom_range(0, 8191)) : $urandom;
                    mem = 1;
                end
            endcase
            model(v, mem, elat, eenc, eop);
            launch_and_wait(v, mem, lat);
            chk($sformatf("rnd%0d_lat v=%h", i, v), lat, elat);
            chk($sformatf("rnd%0d_enc v=%h", i, v), encodable, eenc);
            chk($sformatf("rnd%0d_op v=%h", i, v), shift_operand, eop);
            if (!mem && encodable)
                chk($sformatf("rnd%0d_decode", i),
                    ror({24'd0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8])), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
